// File: rtl/simplerisc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : simplerisc_pkg                                                |
// | Purpose  : Shared constants and enumerations for the SimpleRISC          |
// |            register-file writeback scheduler.                            |
// | Contents : NREG/AW/DW sizing constants, wb_src_e (write-port source),    |
// |            prio_e (arbiter priority state).                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package simplerisc_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

  // Arbiter priority state.
  typedef enum logic [0:0] {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } prio_e;

endpackage : simplerisc_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_port_arbiter                                               |
// | Purpose  : Two-way combinational arbiter for the single register-file    |
// |            write port (ALU vs. memory writeback).                        |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            alu_valid, mem_valid  -> request inputs                       |
// |            alu_grant, mem_grant  <- one-hot-or-zero grants               |
// |            src                   <- granted source as wb_src_e           |
// | Config   : STARVE_EN - when defined, a saturating counter of ALU losses  |
// |            moves priority to the ALU after STARVE_LIMIT losses. When     |
// |            undefined, priority is fixed at PRIO_MEM and no counter       |
// |            exists.                                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_port_arbiter
  import simplerisc_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_valid,
  input  logic    mem_valid,
  output logic    alu_grant,
  output logic    mem_grant,
  output wb_src_e src
);

  prio_e prio_q;
  prio_e prio_d;

  // Winner selection from the current priority state.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    src       = WB_NONE;
    if (prio_q == PRIO_ALU) begin
      alu_grant = alu_valid;
      mem_grant = mem_valid & ~alu_valid;
    end else begin
      mem_grant = mem_valid;
      alu_grant = alu_valid & ~mem_valid;
    end
    if (alu_grant) begin
      src = WB_ALU;
    end else if (mem_grant) begin
      src = WB_MEM;
    end
  end

`ifdef STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;

  // Counter and priority next state. The switch to PRIO_ALU is keyed on the
  // next count so the ALU wins in the cycle right after its LIMIT-th loss.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    prio_d       = prio_q;
    if (alu_grant) begin
      starve_cnt_d = '0;
      prio_d       = PRIO_MEM;
    end else begin
      if (alu_valid && (starve_cnt_q < CW'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
      if (starve_cnt_d == CW'(STARVE_LIMIT)) begin
        prio_d = PRIO_ALU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict memory priority: the state register never leaves PRIO_MEM.
  always_comb begin
    prio_d = PRIO_MEM;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= PRIO_MEM;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : wb_port_arbiter
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_wb_scheduler                                          |
// | Purpose  : Busy scoreboard, RAW/WAW issue stall, and writeback port      |
// |            scheduling for the 16x32 SimpleRISC register file.            |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            iss_*      issue request from decode, iss_stall back         |
// |            alu_wb_*   ALU writeback valid/rd/data, alu_wb_ready back     |
// |            mem_wb_*   load writeback valid/rd/data, mem_wb_ready back    |
// |            rf_isWb/rf_rd/rf_data  registered register-file write port    |
// |            busy_mask  current scoreboard, wb_err sticky error flag       |
// | Config   : STARVE_EN - enables ALU anti-starvation in wb_port_arbiter.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_wb_scheduler
  import simplerisc_pkg::*;
#(
  parameter int unsigned NREG         = simplerisc_pkg::NREG,
  parameter int unsigned AW           = simplerisc_pkg::AW,
  parameter int unsigned DW           = simplerisc_pkg::DW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_wr,
  output logic            iss_stall,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_rd,
  input  logic [DW-1:0]   alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [AW-1:0]   mem_wb_rd,
  input  logic [DW-1:0]   mem_wb_data,
  output logic            mem_wb_ready,
  output logic            rf_isWb,
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_data,
  output logic [NREG-1:0] busy_mask,
  output logic            wb_err
);

  logic [NREG-1:0] busy_q,    busy_d;
  logic            rf_isWb_q, rf_isWb_d;
  logic [AW-1:0]   rf_rd_q,   rf_rd_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic            wb_err_q,  wb_err_d;

  wb_src_e         wb_src;
  logic            wb_grant;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            iss_fire_wr;

  wb_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_wb_valid),
    .mem_valid (mem_wb_valid),
    .alu_grant (alu_wb_ready),
    .mem_grant (mem_wb_ready),
    .src       (wb_src)
  );

  // Hazard check against the scoreboard as it stands this cycle (no bypass).
  always_comb begin
    iss_stall   = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] |
                               (iss_wr & busy_q[iss_rd]));
    iss_fire_wr = iss_valid & ~iss_stall & iss_wr;
  end

  // Write-port mux from the arbitration winner.
  always_comb begin
    wb_grant = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    case (wb_src)
      WB_ALU: begin
        wb_grant = 1'b1;
        wb_rd    = alu_wb_rd;
        wb_data  = alu_wb_data;
      end
      WB_MEM: begin
        wb_grant = 1'b1;
        wb_rd    = mem_wb_rd;
        wb_data  = mem_wb_data;
      end
      default: begin
        wb_grant = 1'b0;
      end
    endcase
  end

  // Scoreboard and output-register next state. The set is applied after the
  // clear so a same-edge set/clear on one bit leaves it reserved.
  always_comb begin
    busy_d    = busy_q;
    rf_isWb_d = wb_grant;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    wb_err_d  = wb_err_q;
    if (wb_grant) begin
      busy_d[wb_rd] = 1'b0;
      rf_rd_d       = wb_rd;
      rf_data_d     = wb_data;
      // Writing a register nobody reserved is still performed, but flagged.
      if (!busy_q[wb_rd]) begin
        wb_err_d = 1'b1;
      end
    end
    if (iss_fire_wr) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rf_isWb_q <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rf_isWb_q <= rf_isWb_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign rf_isWb   = rf_isWb_q;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;
  assign busy_mask = busy_q;
  assign wb_err    = wb_err_q;

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_wb_scheduler                                       |
// | Purpose  : Directed self-checking bench for regfile_wb_scheduler.        |
// |            Covers reset, RAW, WAW, ALU/mem conflict, sticky error,       |
// |            reset mid-operation and ALU starvation (STARVE_EN aware).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_wr;
  logic        iss_stall;
  logic        alu_wb_valid;
  logic [3:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [3:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        rf_isWb;
  logic [3:0]  rf_rd;
  logic [31:0] rf_data;
  logic [15:0] busy_mask;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_wr       (iss_wr),
    .iss_stall    (iss_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .rf_isWb      (rf_isWb),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .busy_mask    (busy_mask),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid    = 1'b0;
    iss_rs1      = 4'd0;
    iss_rs2      = 4'd0;
    iss_rd       = 4'd0;
    iss_wr       = 1'b0;
    alu_wb_valid = 1'b0;
    alu_wb_rd    = 4'd0;
    alu_wb_data  = 32'd0;
    mem_wb_valid = 1'b0;
    mem_wb_rd    = 4'd0;
    mem_wb_data  = 32'd0;
  endtask

  task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic wr);
    iss_valid = 1'b1;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_rd    = rd;
    iss_wr    = wr;
  endtask

  logic exp_alu;

  initial begin
    // ---------------- 1. reset with all valids high ----------------
    idle();
    rst_n = 1'b0;
    issue(4'd0, 4'd0, 4'd0, 1'b1);
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd1; alu_wb_data = 32'h11;
    mem_wb_valid = 1'b1; mem_wb_rd = 4'd2; mem_wb_data = 32'h22;
    tick(); tick(); tick();
    chk("rst_isWb",  {31'd0, rf_isWb}, 32'd0);
    chk("rst_busy",  {16'd0, busy_mask}, 32'd0);
    chk("rst_err",   {31'd0, wb_err}, 32'd0);
    chk("rst_rd",    {28'd0, rf_rd}, 32'd0);
    chk("rst_data",  rf_data, 32'd0);
    chk("rst_memrdy",{31'd0, mem_wb_ready}, 32'd1);
    chk("rst_alurdy",{31'd0, alu_wb_ready}, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {16'd0, busy_mask}, 32'd0);

    // ---------------- 2. RAW hazard ----------------
    issue(4'd0, 4'd0, 4'd5, 1'b1);
    #1 chk("raw_first_stall", {31'd0, iss_stall}, 32'd0);
    tick();
    chk("raw_busy5", {16'd0, busy_mask}, 32'h0020);
    issue(4'd5, 4'd0, 4'd6, 1'b1);
    #1 chk("raw_stall", {31'd0, iss_stall}, 32'd1);
    tick();
    chk("raw_stall_noset", {16'd0, busy_mask}, 32'h0020);
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd5; alu_wb_data = 32'h2A;
    #1 chk("raw_alurdy", {31'd0, alu_wb_ready}, 32'd1);
    chk("raw_stall_at_grant", {31'd0, iss_stall}, 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    chk("raw_isWb", {31'd0, rf_isWb}, 32'd1);
    chk("raw_rd",   {28'd0, rf_rd}, 32'd5);
    chk("raw_data", rf_data, 32'h2A);
    chk("raw_busy_clr", {16'd0, busy_mask}, 32'd0);
    #1 chk("raw_stall_drop", {31'd0, iss_stall}, 32'd0);
    tick();
    idle();
    chk("raw_isWb_low", {31'd0, rf_isWb}, 32'd0);
    chk("raw_rd_hold",  {28'd0, rf_rd}, 32'd5);
    chk("raw_data_hold", rf_data, 32'h2A);
    chk("raw_busy6", {16'd0, busy_mask}, 32'h0040);
    mem_wb_valid = 1'b1; mem_wb_rd = 4'd6; mem_wb_data = 32'h66;
    tick();
    idle();
    chk("raw_busy6_clr", {16'd0, busy_mask}, 32'd0);

    // ---------------- 3. WAW hazard ----------------
    issue(4'd0, 4'd0, 4'd3, 1'b1);
    tick();
    chk("waw_busy3", {16'd0, busy_mask}, 32'h0008);
    issue(4'd0, 4'd0, 4'd3, 1'b1);
    #1 chk("waw_stall", {31'd0, iss_stall}, 32'd1);
    iss_wr = 1'b0;
    #1 chk("waw_nowr_stall", {31'd0, iss_stall}, 32'd0);
    tick();
    idle();
    chk("waw_busy_keep", {16'd0, busy_mask}, 32'h0008);
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd3; alu_wb_data = 32'h33;
    tick();
    idle();
    chk("waw_busy_clr", {16'd0, busy_mask}, 32'd0);

    // ---------------- 4. ALU/mem conflict ----------------
    issue(4'd0, 4'd0, 4'd1, 1'b1);
    tick();
    issue(4'd0, 4'd0, 4'd2, 1'b1);
    tick();
    idle();
    chk("cf_busy", {16'd0, busy_mask}, 32'h0006);
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd1; alu_wb_data = 32'h11;
    mem_wb_valid = 1'b1; mem_wb_rd = 4'd2; mem_wb_data = 32'h22;
    #1 chk("cf_memrdy", {31'd0, mem_wb_ready}, 32'd1);
    chk("cf_alurdy0", {31'd0, alu_wb_ready}, 32'd0);
    tick();
    mem_wb_valid = 1'b0;
    chk("cf_rd_mem",   {28'd0, rf_rd}, 32'd2);
    chk("cf_data_mem", rf_data, 32'h22);
    chk("cf_busy1",    {16'd0, busy_mask}, 32'h0002);
    #1 chk("cf_alurdy1", {31'd0, alu_wb_ready}, 32'd1);
    tick();
    idle();
    chk("cf_isWb_alu", {31'd0, rf_isWb}, 32'd1);
    chk("cf_rd_alu",   {28'd0, rf_rd}, 32'd1);
    chk("cf_data_alu", rf_data, 32'h11);
    chk("cf_busy0",    {16'd0, busy_mask}, 32'd0);
    chk("cf_no_err",   {31'd0, wb_err}, 32'd0);

    // ---------------- 6. unreserved writeback error ----------------
    mem_wb_valid = 1'b1; mem_wb_rd = 4'd9; mem_wb_data = 32'h99;
    #1 chk("err_memrdy", {31'd0, mem_wb_ready}, 32'd1);
    tick();
    idle();
    chk("err_isWb", {31'd0, rf_isWb}, 32'd1);
    chk("err_rd",   {28'd0, rf_rd}, 32'd9);
    chk("err_data", rf_data, 32'h99);
    chk("err_set",  {31'd0, wb_err}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, wb_err}, 32'd1);

    // ---------------- reset mid-operation ----------------
    issue(4'd0, 4'd0, 4'd4, 1'b1);
    tick();
    idle();
    chk("mid_busy4", {16'd0, busy_mask}, 32'h0010);
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd4; alu_wb_data = 32'h44;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_isWb", {31'd0, rf_isWb}, 32'd0);
    chk("mid_rst_busy", {16'd0, busy_mask}, 32'd0);
    chk("mid_rst_err",  {31'd0, wb_err}, 32'd0);
    chk("mid_rst_data", rf_data, 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // ---------------- 5. ALU starvation ----------------
    mem_wb_valid = 1'b1; mem_wb_rd = 4'd8; mem_wb_data = 32'h88;
    alu_wb_valid = 1'b1; alu_wb_rd = 4'd10; alu_wb_data = 32'hAA;
    for (int i = 1; i <= 6; i++) begin
`ifdef STARVE_EN
      exp_alu = (i == 5);
`else
      exp_alu = 1'b0;
`endif
      #1;
      chk($sformatf("stv_alurdy_c%0d", i), {31'd0, alu_wb_ready}, {31'd0, exp_alu});
      chk($sformatf("stv_memrdy_c%0d", i), {31'd0, mem_wb_ready}, {31'd0, ~exp_alu});
      tick();
      chk($sformatf("stv_rd_c%0d", i), {28'd0, rf_rd}, exp_alu ? 32'd10 : 32'd8);
      if (exp_alu) alu_wb_valid = 1'b0;
    end
`ifndef STARVE_EN
    mem_wb_valid = 1'b0;
    #1 chk("stv_alu_after_mem", {31'd0, alu_wb_ready}, 32'd1);
    tick();
    chk("stv_alu_rd", {28'd0, rf_rd}, 32'd10);
    chk("stv_alu_data", rf_data, 32'hAA);
`endif
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire
